// File: rtl/cache_mem_interface.sv
// Memory-side stage behind cache_controller: refills and buffered write-backs
// become single-beat block transactions on the memory bus.
module cache_mem_interface #(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned OFFSET_W = 4,
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        allocate,
  input  logic                        write_back,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [ADDR_W-1:0]           victim_addr,
  output logic                        mem_ready,
  output logic                        wb_full,
  output logic [$clog2(WB_DEPTH):0]   wb_count,
  output logic                        bus_req,
  output logic                        bus_we,
  output logic [ADDR_W-1:0]           bus_addr,
  input  logic                        bus_ack,
  output logic                        err_ovf
);

  localparam int unsigned PTR_W = $clog2(WB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RD, RD_DONE, WB} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fifo_q [WB_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                wb_full_q, wb_full_d;
  logic                rf_pend_q, rf_pend_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic                mem_ready_q, mem_ready_d;
  logic                bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic                err_ovf_q, err_ovf_d;

  logic                push_c, pop_c, alloc_c, rf_avail_c, hazard_c;
  logic [ADDR_W-1:0]   push_addr_c, rf_addr_eff_c;

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
  endfunction

  // Next-state logic: capture, hazard detection, FSM and FIFO bookkeeping
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    rf_pend_d   = rf_pend_q;
    rf_addr_d   = rf_addr_q;
    mem_ready_d = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    err_ovf_d   = err_ovf_q;
    pop_c       = 1'b0;
    hazard_c    = 1'b0;

    push_c        = write_back && !wb_full_q;
    push_addr_c   = align(victim_addr);
    alloc_c       = allocate && !rf_pend_q;
    rf_avail_c    = rf_pend_q || alloc_c;
    rf_addr_eff_c = rf_pend_q ? rf_addr_q : align(addr);

    if ((write_back && wb_full_q) || (allocate && rf_pend_q)) err_ovf_d = 1'b1;
    if (alloc_c) begin
      rf_pend_d = 1'b1;
      rf_addr_d = rf_addr_eff_c;
    end

    // Refill must not read a block still waiting to be written back
    for (int unsigned k = 0; k < WB_DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) && (fifo_q[rd_ptr_q + PTR_W'(k)] == rf_addr_eff_c))
        hazard_c = 1'b1;
    end
    if (push_c && (push_addr_c == rf_addr_eff_c)) hazard_c = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (rf_avail_c && !hazard_c) begin
          state_d    = RD;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = rf_addr_eff_c;
        end else if (count_q != '0) begin
          state_d    = WB;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b1;
          bus_addr_d = fifo_q[rd_ptr_q];
        end
      end
      RD: begin
        if (bus_ack) begin
          state_d     = RD_DONE;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          rf_pend_d   = 1'b0;
          mem_ready_d = 1'b1;
        end
      end
      RD_DONE: state_d = IDLE;
      WB: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          pop_c     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d   = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    wb_full_d = (count_d == CNT_W'(WB_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wb_full_q   <= 1'b0;
      rf_pend_q   <= 1'b0;
      rf_addr_q   <= '0;
      mem_ready_q <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      wb_full_q   <= wb_full_d;
      rf_pend_q   <= rf_pend_d;
      rf_addr_q   <= rf_addr_d;
      mem_ready_q <= mem_ready_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // Write-back storage; validity is tracked by the pointers and count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < WB_DEPTH; k++) fifo_q[k] <= '0;
    end else if (push_c) begin
      fifo_q[wr_ptr_q] <= push_addr_c;
    end
  end

  assign mem_ready = mem_ready_q;
  assign wb_full   = wb_full_q;
  assign wb_count  = count_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign err_ovf   = err_ovf_q;

endmodule
